// File: rtl/uart_cmd_ctrl.sv
// Host command decoder: turns uart_rx opcode/argument bytes into tpu_bridge ctrl_* strobes
// and streams MLP status / accumulator bytes back to uart_tx over valid/ready.
//
// state   | meaning
// S_IDLE  | waiting for an opcode byte
// S_ARG1  | waiting for first argument byte (weight byte or activation lo)
// S_ARG2  | waiting for activation hi byte
// S_EXEC  | command issued; response (if any) snapshotted here
// S_TX    | presenting response bytes to uart_tx
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               ctrl_wf_push_col0,
  output logic               ctrl_wf_push_col1,
  output logic [7:0]         ctrl_wf_data_in,
  output logic               ctrl_wf_reset,
  output logic               ctrl_init_act_valid,
  output logic [15:0]        ctrl_init_act_data,
  output logic               ctrl_start_mlp,
  output logic               ctrl_weights_ready,
  input  logic [2:0]         mlp_state,
  input  logic [4:0]         mlp_cycle_cnt,
  input  logic signed [31:0] mlp_acc0,
  output logic               rx_overrun
);

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ARG1, S_ARG2, S_EXEC, S_TX} state_t;

  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d, lo_q, lo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    idx_q, idx_d, last_q, last_d;
  logic [31:0]   resp_q, resp_d;
  logic          err_q, err_d;
  logic          push0_d, push1_d, wf_reset_d, act_valid_d, start_d, ready_d, ovr_d;
  logic [7:0]    wf_data_d;
  logic [15:0]   act_data_d;

  assign tx_valid = (state_q == S_TX);
  assign tx_data  = resp_q[8*idx_q +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q             <= S_IDLE;
      op_q                <= '0;
      lo_q                <= '0;
      tmo_q               <= '0;
      idx_q               <= '0;
      last_q              <= '0;
      resp_q              <= '0;
      err_q               <= 1'b0;
      ctrl_wf_push_col0   <= 1'b0;
      ctrl_wf_push_col1   <= 1'b0;
      ctrl_wf_data_in     <= '0;
      ctrl_wf_reset       <= 1'b0;
      ctrl_init_act_valid <= 1'b0;
      ctrl_init_act_data  <= '0;
      ctrl_start_mlp      <= 1'b0;
      ctrl_weights_ready  <= 1'b0;
      rx_overrun          <= 1'b0;
    end else begin
      state_q             <= state_d;
      op_q                <= op_d;
      lo_q                <= lo_d;
      tmo_q               <= tmo_d;
      idx_q               <= idx_d;
      last_q              <= last_d;
      resp_q              <= resp_d;
      err_q               <= err_d;
      ctrl_wf_push_col0   <= push0_d;
      ctrl_wf_push_col1   <= push1_d;
      ctrl_wf_data_in     <= wf_data_d;
      ctrl_wf_reset       <= wf_reset_d;
      ctrl_init_act_valid <= act_valid_d;
      ctrl_init_act_data  <= act_data_d;
      ctrl_start_mlp      <= start_d;
      ctrl_weights_ready  <= ready_d;
      rx_overrun          <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lo_d        = lo_q;
    tmo_d       = tmo_q;
    idx_d       = idx_q;
    last_d      = last_q;
    resp_d      = resp_q;
    err_d       = err_q;
    push0_d     = 1'b0;
    push1_d     = 1'b0;
    wf_reset_d  = 1'b0;
    act_valid_d = 1'b0;
    start_d     = 1'b0;
    wf_data_d   = ctrl_wf_data_in;
    act_data_d  = ctrl_init_act_data;
    ready_d     = ctrl_weights_ready;
    ovr_d       = rx_overrun;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          op_d  = rx_data;
          tmo_d = '0;
          err_d = 1'b0;
          // zero-argument commands act on the opcode cycle so strobes land with EXEC
          case (rx_data)
            8'h01, 8'h02, 8'h03: state_d = S_ARG1;
            8'h04: begin
              ready_d = 1'b1;
              state_d = S_EXEC;
            end
            8'h05: begin
              if (ctrl_weights_ready) start_d = 1'b1;
              else                    err_d   = 1'b1;
              state_d = S_EXEC;
            end
            8'h06, 8'h07: state_d = S_EXEC;
            8'h08: begin
              wf_reset_d = 1'b1;
              ready_d    = 1'b0;
              state_d    = S_EXEC;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_EXEC;
            end
          endcase
        end
      end
      S_ARG1, S_ARG2: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (state_q == S_ARG1 && op_q == 8'h03) begin
            lo_d    = rx_data;
            state_d = S_ARG2;
          end else begin
            state_d = S_EXEC;
            if (op_q == 8'h01) begin
              push0_d   = 1'b1;
              wf_data_d = rx_data;
            end else if (op_q == 8'h02) begin
              push1_d   = 1'b1;
              wf_data_d = rx_data;
            end else begin
              act_valid_d = 1'b1;
              act_data_d  = {rx_data, lo_q};
            end
          end
        end else if (tmo_q == TMO_MAX) begin
          state_d = S_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (rx_valid) ovr_d = 1'b1;
        idx_d = '0;
        if (err_q) begin
          resp_d  = {24'd0, ERR_BYTE};
          last_d  = 2'd0;
          state_d = S_TX;
        end else if (op_q == 8'h06) begin
          resp_d  = {24'd0, mlp_state, mlp_cycle_cnt};
          last_d  = 2'd0;
          state_d = S_TX;
        end else if (op_q == 8'h07) begin
          resp_d  = mlp_acc0;
          last_d  = 2'd3;
          state_d = S_TX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TX: begin
        if (rx_valid) ovr_d = 1'b1;
        if (tx_ready) begin
          if (idx_q == last_q) state_d = S_IDLE;
          else                 idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: a command-level model predicts every output each cycle,
// and directed scenarios pin key results against hand-computed literals.
module tb_uart_cmd_ctrl;
  localparam int unsigned TMO = 16;
  localparam logic [7:0]  ERR = 8'hEE;

  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0] rx_data = '0;
  logic tx_valid, push0, push1, wf_reset, act_valid, start_mlp, weights_ready, overrun;
  logic [7:0] tx_data, wf_data;
  logic [15:0] act_data;
  logic [2:0] mlp_state = 3'd5;
  logic [4:0] mlp_cycle_cnt = 5'd19;
  logic signed [31:0] mlp_acc0 = '0;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .ERR_BYTE(ERR)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .ctrl_wf_push_col0(push0), .ctrl_wf_push_col1(push1), .ctrl_wf_data_in(wf_data),
    .ctrl_wf_reset(wf_reset), .ctrl_init_act_valid(act_valid), .ctrl_init_act_data(act_data),
    .ctrl_start_mlp(start_mlp), .ctrl_weights_ready(weights_ready),
    .mlp_state(mlp_state), .mlp_cycle_cnt(mlp_cycle_cnt), .mlp_acc0(mlp_acc0),
    .rx_overrun(overrun)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command-level model: collects bytes into a command, executes it when complete,
  // then is busy for one issue cycle plus however long its response takes to drain.
  logic [7:0]  cmd[$];
  logic [7:0]  resp_q[$];
  int          idle_cnt = 0, m_resp = 0;
  bit          m_exec = 0, started = 0;
  logic        m_push0 = 0, m_push1 = 0, m_wfrst = 0, m_actv = 0, m_start = 0, m_ready = 0, m_ovr = 0;
  logic [7:0]  m_wfdata = '0;
  logic [15:0] m_actdata = '0;
  logic [31:0] acc_snap;

  function automatic int cmd_len(input logic [7:0] op);
    if (op == 8'h01 || op == 8'h02) return 2;
    if (op == 8'h03) return 3;
    return 1;
  endfunction

  initial forever begin
    @(posedge clk);
    m_push0 = 0; m_push1 = 0; m_wfrst = 0; m_actv = 0; m_start = 0;
    if (!rst_n) begin
      cmd.delete(); resp_q.delete();
      idle_cnt = 0; m_exec = 0; m_resp = 0;
      m_ready = 0; m_ovr = 0; m_wfdata = '0; m_actdata = '0;
      started = 1;
    end else if (m_exec) begin
      m_exec = 0;
      if (rx_valid) m_ovr = 1;
      case (m_resp)
        1: resp_q.push_back(ERR);
        2: resp_q.push_back({mlp_state, mlp_cycle_cnt});
        3: begin
          acc_snap = mlp_acc0;
          for (int k = 0; k < 4; k++) resp_q.push_back(acc_snap[8*k +: 8]);
        end
        default: ;
      endcase
    end else if (resp_q.size() > 0) begin
      if (rx_valid) m_ovr = 1;
      if (tx_ready) void'(resp_q.pop_front());
    end else if (rx_valid) begin
      cmd.push_back(rx_data);
      idle_cnt = 0;
      if (cmd.size() == cmd_len(cmd[0])) begin
        m_resp = 0;
        case (cmd[0])
          8'h01: begin m_push0 = 1; m_wfdata = cmd[1]; end
          8'h02: begin m_push1 = 1; m_wfdata = cmd[1]; end
          8'h03: begin m_actv = 1; m_actdata = {cmd[2], cmd[1]}; end
          8'h04: m_ready = 1;
          8'h05: if (m_ready) m_start = 1; else m_resp = 1;
          8'h06: m_resp = 2;
          8'h07: m_resp = 3;
          8'h08: begin m_wfrst = 1; m_ready = 0; end
          default: m_resp = 1;
        endcase
        cmd.delete();
        m_exec = 1;
      end
    end else if (cmd.size() > 0) begin
      if (idle_cnt == TMO) begin cmd.delete(); idle_cnt = 0; end
      else idle_cnt++;
    end
  end

  // Per-cycle compare plus observation log for the literal checks.
  logic [7:0] tx_log[$];
  int n_push0 = 0, n_push1 = 0, n_actv = 0, n_start = 0, n_wfrst = 0;
  logic [7:0] seen_wf0 = '0, seen_wf1 = '0;
  logic [15:0] seen_act = '0;

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("push_col0", push0, m_push0);
      chk("push_col1", push1, m_push1);
      chk("wf_data_in", wf_data, m_wfdata);
      chk("wf_reset", wf_reset, m_wfrst);
      chk("act_valid", act_valid, m_actv);
      chk("act_data", act_data, m_actdata);
      chk("start_mlp", start_mlp, m_start);
      chk("weights_ready", weights_ready, m_ready);
      chk("rx_overrun", overrun, m_ovr);
      chk("tx_valid", tx_valid, resp_q.size() > 0);
      if (resp_q.size() > 0) chk("tx_data", tx_data, resp_q[0]);
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (push0) begin n_push0++; seen_wf0 = wf_data; end
      if (push1) begin n_push1++; seen_wf1 = wf_data; end
      if (act_valid) begin n_actv++; seen_act = act_data; end
      if (start_mlp) n_start++;
      if (wf_reset) n_wfrst++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_exec || resp_q.size() > 0 || tx_valid) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", n);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int base;
    // WDONE presented while reset is held must be ignored
    @(posedge clk); #2; rx_valid = 1'b1; rx_data = 8'h04;
    @(posedge clk); #2; rx_valid = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
    chk("reset_ready", weights_ready, 1'b0);
    chk("reset_tx_valid", tx_valid, 1'b0);

    tx_log.delete();
    send(8'h05); wait_idle();
    chk("start_unready_len", tx_log.size(), 1);
    chk("start_unready_err", tx_log[0], 8'hEE);
    chk("start_unready_nostart", n_start, 0);

    send(8'h01); send(8'h5A);
    send(8'h02); send(8'hA5); wait_idle();
    chk("w0_count", n_push0, 1);
    chk("w0_data", seen_wf0, 8'h5A);
    chk("w1_count", n_push1, 1);
    chk("w1_data", seen_wf1, 8'hA5);

    send(8'h03); send(8'h34); send(8'h12); wait_idle();
    chk("act_count", n_actv, 1);
    chk("act_data_lit", seen_act, 16'h1234);

    send(8'h04); wait_idle();
    chk("wdone_ready", weights_ready, 1'b1);
    send(8'h05); wait_idle();
    chk("start_count", n_start, 1);
    send(8'h04); wait_idle();
    chk("wdone_again_ready", weights_ready, 1'b1);

    send(8'h08); wait_idle();
    chk("wrst_count", n_wfrst, 1);
    chk("wrst_ready", weights_ready, 1'b0);

    // ACC: toggling tx_ready and a mid-send accumulator change
    mlp_acc0 = 32'h89ABCDEF;
    tx_log.delete();
    send(8'h07);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #2;
      tx_ready = i[0];
      if (i == 3) mlp_acc0 = 32'h11223344;
    end
    tx_ready = 1'b1;
    wait_idle();
    chk("acc_len", tx_log.size(), 4);
    chk("acc_b0", tx_log[0], 8'hEF);
    chk("acc_b1", tx_log[1], 8'hCD);
    chk("acc_b2", tx_log[2], 8'hAB);
    chk("acc_b3", tx_log[3], 8'h89);

    // partial ACT abandoned by timeout; the following STATUS is decoded as an opcode
    base = n_actv;
    tx_log.delete();
    send(8'h03); send(8'h34);
    repeat (TMO + 5) @(posedge clk);
    send(8'h06); wait_idle();
    chk("timeout_no_act", n_actv, base);
    chk("timeout_status_len", tx_log.size(), 1);
    chk("timeout_status", tx_log[0], 8'hB3);

    // arguments arriving inside the timeout window still complete the command
    send(8'h03); send(8'h78);
    repeat (TMO - 4) @(posedge clk);
    send(8'h56); wait_idle();
    chk("slow_act_count", n_actv, base + 1);
    chk("slow_act_data", seen_act, 16'h5678);

    // unknown opcode; a byte arriving during TX_SEND is dropped
    tx_ready = 1'b0;
    tx_log.delete();
    send(8'h7F);
    repeat (3) @(posedge clk);
    send(8'h04);
    @(posedge clk); #2; tx_ready = 1'b1;
    wait_idle();
    chk("unknown_len", tx_log.size(), 1);
    chk("unknown_err", tx_log[0], 8'hEE);
    chk("overrun_set", overrun, 1'b1);
    chk("dropped_not_decoded", weights_ready, 1'b0);

    // reset in the middle of a command discards it and clears the overrun flag
    send(8'h01);
    @(posedge clk); #2; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    chk("reset_clears_overrun", overrun, 1'b0);
    base = n_push0;
    tx_log.delete();
    send(8'h06); wait_idle();
    chk("reset_discard_nopush", n_push0, base);
    chk("reset_discard_status", tx_log[0], 8'hB3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
